axi_line_write_bridge: RTL and testbench
========================================

Name: axi_line_write_bridge

Overview:
- Memory-side responder for the data-cache write buffer's line-write port: accepts one 256-bit dirty line per request (`mem_wen`/`mem_awaddr`/`mem_wdata`) and issues it as a single AXI3 INCR burst (8 x 32-bit beats).
- Returns a one-cycle `mem_bvalid` pulse when the AXI write response completes.
- Sits between the write buffer and the AXI interconnect.
- Handles exactly one line in flight.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, line width in bits.
- DATA_W, 32, AXI data width; BEATS = LINE_W/DATA_W = 8.
- AXI_ID, 4'h1, constant AWID/WID driven on all transactions.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_wen_i  in  1  line-write request; held high until `mem_bvalid_o`.
- mem_awaddr_i  in  ADDR_W  line address; bits [4:0] ignored.
- mem_wdata_i  in  LINE_W  line data; word k = bits [32k+31:32k].
- mem_bvalid_o  out  1  one-cycle completion pulse.
- busy_o  out  1  high in any state other than IDLE.
- resp_err_o  out  1  sticky; set on BRESP != OKAY.
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  out  4/ADDR_W/4/3/2/2/4/3  AXI AW payload.
- awvalid  out  1 / awready  in  1.
- wid/wdata/wstrb/wlast  out  4/DATA_W/4/1 / wvalid  out  1 / wready  in  1.
- bid  in  4 / bresp  in  2 / bvalid  in  1 / bready  out  1.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, beat counter=0.
  - awvalid, wvalid, wlast, bready, mem_bvalid_o, resp_err_o, busy_o all 0.
  - Latched address and data are don't-care.
- Constant AXI fields:
  - awlen=4'd7, awsize=3'b010, awburst=2'b01 (INCR).
  - awlock=0, awcache=4'b0000, awprot=3'b000.
  - wstrb=4'hF; awid=wid=AXI_ID.
- States: IDLE, AW, W, B, DONE.
- IDLE:
  - If mem_wen_i=1 at an edge: latch {mem_awaddr_i[31:5],5'h0} and mem_wdata_i, go to AW.
  - awvalid is registered and rises the cycle after acceptance.
  - Later changes on mem_wdata_i are ignored; the buffer resends on a write collision, so the in-flight snapshot stays self-consistent.
- AW:
  - awvalid=1, awaddr=latched line base; both held stable until awvalid&awready.
  - On handshake go to W with beat=0.
- W:
  - wvalid=1, wdata=latched word[beat], wlast=(beat==7).
  - On wvalid&wready: beat increments.
  - Beat 7 accepted: go to B, wvalid drops next cycle.
  - wdata is held stable while wready=0; no beat is skipped or duplicated.
- B:
  - bready=1.
  - On bvalid: go to DONE; if bresp!=2'b00, set resp_err_o (cleared only by reset).
  - bid is not checked.
- DONE:
  - mem_bvalid_o=1 for exactly this cycle, then IDLE.
  - mem_wen_i is ignored in DONE; the buffer drops wen in this cycle anyway.
  - A request still high in the next IDLE cycle is the next head entry, or the same entry when a rewrite occurred; it is accepted normally.
- Minimum latency, all ready signals high: wen sampled at edge 0; awvalid during cycle 1; beats cycles 2..9; bvalid earliest cycle 10; mem_bvalid_o cycle 11.
- Error response: still completes with mem_bvalid_o; no retry.
- Reset mid-transfer: AXI valids drop immediately. The next request restarts from a fresh AW; the interconnect is reset together with the bridge.

Optional Feature:
- Macro: AXI_AW_W_PARALLEL_EN.
- Defined:
  - From IDLE, assert awvalid and wvalid together; beat 0 may complete before, with, or after AW.
  - Enter B only when both the AW handshake and the beat-7 handshake are done.
  - Min latency drops by 1 cycle.
- Undefined:
  - Strictly sequential AW then W, as in Behaviour.

Test Plan:
- Single write, mem_awaddr_i=32'h1FC0_0034, data words k=32'hA000_000k, all readies 1 -> awaddr=32'h1FC0_0020, awlen=7, beats A0000000..A0000007 in order, wlast only on beat 8, mem_bvalid_o high exactly 1 cycle at cycle 11.
- awready delayed 3 cycles, wready toggling 1,0,1,0 -> AW payload stable while waiting, exactly 8 accepted beats in order, wdata unchanged across stalled cycles.
- Back-to-back: wen stays high with a new line (addr 32'h0000_1040) the cycle after the pulse -> second AW issued at 32'h0000_1040, no second pulse before its B.
- mem_wdata_i changed to all-ones after acceptance -> burst carries the originally latched words.
- bresp=2'b10 on B -> mem_bvalid_o still pulses once, resp_err_o=1 and stays 1 through the next OKAY transfer.
- rst low during beat 4 -> awvalid/wvalid/bready=0 immediately, busy_o=0; after release a new request sends beat 0 first.

Source files
------------

// File: rtl/axi_line_write_bridge_if.sv
// AXI3 write-channel bundle between the line-write bridge and the interconnect.
// master = bridge side, slave = interconnect side.
interface axi_line_write_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [3:0]          awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [3:0]          wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [3:0]          bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
        output awvalid, wid, wdata, wstrb, wlast, wvalid, bready,
        input  awready, wready, bid, bresp, bvalid
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
        input  awvalid, wid, wdata, wstrb, wlast, wvalid, bready,
        output awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/axi_line_write_bridge.sv
// Turns one dirty cache line into a single AXI3 INCR burst and pulses on BRESP.
// Define AXI_AW_W_PARALLEL_EN to issue AW and W concurrently.
module axi_line_write_bridge #(
    parameter int         ADDR_W = 32,
    parameter int         LINE_W = 256,
    parameter int         DATA_W = 32,
    parameter logic [3:0] AXI_ID = 4'h1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_wen_i,
    input  logic [ADDR_W-1:0] mem_awaddr_i,
    input  logic [LINE_W-1:0] mem_wdata_i,
    output logic              mem_bvalid_o,
    output logic              busy_o,
    output logic              resp_err_o,
    axi_line_write_bridge_if.master axi
);
    localparam int BEATS  = LINE_W / DATA_W;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, AW, W, B, DONE} state_e;

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] data_q, data_d;
    logic              err_q, err_d;
`ifdef AXI_AW_W_PARALLEL_EN
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
`endif

    logic aw_fire, w_fire, w_last_fire;
    logic unused_bits;

    assign aw_fire     = axi.awvalid & axi.awready;
    assign w_fire      = axi.wvalid & axi.wready;
    assign w_last_fire = w_fire & (beat_q == LAST);
    assign unused_bits = ^{axi.bid, mem_awaddr_i[OFF_W-1:0]};

    assign axi.awid    = AXI_ID;
    assign axi.awaddr  = addr_q;
    assign axi.awlen   = 4'(BEATS - 1);
    assign axi.awsize  = 3'b010;
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'b0000;
    assign axi.awprot  = 3'b000;
    assign axi.wid     = AXI_ID;
    assign axi.wdata   = data_q[int'(beat_q) * DATA_W +: DATA_W];
    assign axi.wstrb   = '1;
    assign axi.wlast   = axi.wvalid & (beat_q == LAST);
    assign axi.bready  = (state_q == B);
`ifdef AXI_AW_W_PARALLEL_EN
    assign axi.awvalid = (state_q == AW) & ~aw_done_q;
    assign axi.wvalid  = (state_q == AW) & ~w_done_q;
`else
    assign axi.awvalid = (state_q == AW);
    assign axi.wvalid  = (state_q == W);
`endif

    assign mem_bvalid_o = (state_q == DONE);
    assign busy_o       = (state_q != IDLE);
    assign resp_err_o   = err_q;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
`ifdef AXI_AW_W_PARALLEL_EN
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (mem_wen_i) begin
                    addr_d  = {mem_awaddr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
                    data_d  = mem_wdata_i;
                    beat_d  = '0;
                    state_d = AW;
`ifdef AXI_AW_W_PARALLEL_EN
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
`endif
                end
            end
            AW: begin
`ifdef AXI_AW_W_PARALLEL_EN
                // Either channel may finish first; B waits for both.
                aw_done_d = aw_done_q | aw_fire;
                if (w_fire) beat_d = beat_q + 1'b1;
                if (w_last_fire) w_done_d = 1'b1;
                if (aw_done_d && w_done_d) state_d = B;
`else
                if (aw_fire) begin
                    beat_d  = '0;
                    state_d = W;
                end
`endif
            end
            W: begin
                if (w_fire) beat_d = beat_q + 1'b1;
                if (w_last_fire) state_d = B;
            end
            B: begin
                if (axi.bvalid) begin
                    state_d = DONE;
                    if (axi.bresp != 2'b00) err_d = 1'b1;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            err_q   <= 1'b0;
`ifdef AXI_AW_W_PARALLEL_EN
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
`ifdef AXI_AW_W_PARALLEL_EN
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
`endif
        end
    end

    // Line snapshot needs no reset; it is only observed after a fresh latch.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_axi_line_write_bridge.sv
// Directed bench for axi_line_write_bridge: latency, stalls, back-to-back,
// snapshot isolation, error response and mid-burst reset.
`timescale 1ns/1ps
module tb_axi_line_write_bridge;
    logic         clk;
    logic         rst;
    logic         mem_wen;
    logic [31:0]  mem_awaddr;
    logic [255:0] mem_wdata;
    logic         mem_bvalid;
    logic         busy;
    logic         resp_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] aq[$];
    logic [31:0] wq[$];
    logic        lq[$];

    axi_line_write_bridge_if #(.ADDR_W(32), .DATA_W(32)) axi ();

    axi_line_write_bridge dut (
        .clk         (clk),
        .rst         (rst),
        .mem_wen_i   (mem_wen),
        .mem_awaddr_i(mem_awaddr),
        .mem_wdata_i (mem_wdata),
        .mem_bvalid_o(mem_bvalid),
        .busy_o      (busy),
        .resp_err_o  (resp_err),
        .axi         (axi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (axi.awvalid && axi.awready) aq.push_back(axi.awaddr);
        if (axi.wvalid && axi.wready) begin
            wq.push_back(axi.wdata);
            lq.push_back(axi.wlast);
        end
    end

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + k;
        return l;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_xfer(input logic [31:0] addr, input logic [31:0] exp_addr,
                           input logic [31:0] base, input logic [1:0] resp,
                           input int aw_delay, input bit toggle, input bit clobber,
                           input int exp_aw, input int exp_pulse);
        int          pulse_cyc;
        int          aw_cyc;
        bit          pv;
        bit          pr;
        logic [31:0] pd;
        pulse_cyc = -1;
        aw_cyc    = -1;
        pv = 1'b0;
        pr = 1'b0;
        pd = '0;
        aq.delete();
        wq.delete();
        lq.delete();
        mem_wen     = 1'b1;
        mem_awaddr  = addr;
        mem_wdata   = mk_line(base);
        axi.awready = (aw_delay == 0);
        axi.wready  = 1'b1;
        axi.bvalid  = 1'b0;
        axi.bresp   = resp;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(negedge clk);
            if (clobber && cyc == 1) mem_wdata = '1;
            if (axi.awvalid) begin
                if (aw_cyc < 0) begin
                    aw_cyc = cyc;
                    chk("awlen", axi.awlen, 4'd7);
                    chk("awsize", axi.awsize, 3'b010);
                    chk("awburst", axi.awburst, 2'b01);
                end
                chk("aw_addr", axi.awaddr, exp_addr);
            end
            if (pv && !pr) chk("w_hold", {axi.wvalid, axi.wdata}, {1'b1, pd});
            if (mem_bvalid) begin
                pulse_cyc  = cyc;
                mem_wen    = 1'b0;
                axi.bvalid = 1'b0;
                break;
            end
            axi.awready = (cyc > aw_delay);
            axi.wready  = toggle ? ((cyc % 2) == 1) : 1'b1;
            axi.bvalid  = axi.bready;
            pv = axi.wvalid;
            pr = axi.wready;
            pd = axi.wdata;
        end
        chk("aw_cycle", aw_cyc, exp_aw);
        chk("pulse_cycle", pulse_cyc, exp_pulse);
        chk("aw_count", aq.size(), 1);
        for (int k = 0; k < aq.size(); k++) chk("aw_q", aq[k], exp_addr);
        chk("beat_count", wq.size(), 8);
        for (int k = 0; k < wq.size(); k++) begin
            chk("beat_data", wq[k], base + k);
            chk("beat_last", lq[k], (k == 7));
        end
    endtask

    initial begin
        rst         = 1'b0;
        mem_wen     = 1'b0;
        mem_awaddr  = '0;
        mem_wdata   = '0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        axi.bresp   = 2'b00;
        axi.bid     = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_awvalid", axi.awvalid, 1'b0);
        chk("rst_wvalid", axi.wvalid, 1'b0);
        chk("rst_wlast", axi.wlast, 1'b0);
        chk("rst_bready", axi.bready, 1'b0);
        chk("rst_bvalid_o", mem_bvalid, 1'b0);
        chk("rst_err", resp_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("awid", axi.awid, 4'h1);
        chk("wid", axi.wid, 4'h1);
        chk("wstrb", axi.wstrb, 4'hF);
        chk("awcache", {axi.awlock, axi.awcache, axi.awprot}, 9'h0);
        rst = 1'b1;
        @(negedge clk);

        do_xfer(32'h1FC0_0034, 32'h1FC0_0020, 32'hA000_0000, 2'b00, 0, 0, 0, 1, 11);
        @(negedge clk);
        chk("pulse_width", mem_bvalid, 1'b0);
        chk("idle_busy", busy, 1'b0);
        @(negedge clk);

        do_xfer(32'h0000_2000, 32'h0000_2000, 32'hB000_0000, 2'b00, 3, 1, 0, 1, 21);
        repeat (2) @(negedge clk);

        do_xfer(32'h0000_0800, 32'h0000_0800, 32'hC000_0000, 2'b00, 0, 0, 0, 1, 11);
        do_xfer(32'h0000_1040, 32'h0000_1040, 32'hD000_0000, 2'b00, 0, 0, 0, 2, 12);
        repeat (2) @(negedge clk);

        do_xfer(32'h0000_3000, 32'h0000_3000, 32'hE000_0000, 2'b00, 0, 0, 1, 1, 11);
        repeat (2) @(negedge clk);

        chk("err_before", resp_err, 1'b0);
        do_xfer(32'h0000_4000, 32'h0000_4000, 32'hF000_0000, 2'b10, 0, 0, 0, 1, 11);
        chk("err_set", resp_err, 1'b1);
        repeat (2) @(negedge clk);
        do_xfer(32'h0000_4020, 32'h0000_4020, 32'h1234_0000, 2'b00, 0, 0, 0, 1, 11);
        chk("err_sticky", resp_err, 1'b1);
        repeat (2) @(negedge clk);

        aq.delete();
        wq.delete();
        lq.delete();
        mem_wen     = 1'b1;
        mem_awaddr  = 32'h0000_5000;
        mem_wdata   = mk_line(32'h5555_0000);
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        axi.bvalid  = 1'b0;
        for (int i = 0; i < 30 && wq.size() < 4; i++) @(negedge clk);
        chk("pre_rst_beats", wq.size(), 4);
        chk("pre_rst_wvalid", axi.wvalid, 1'b1);
        chk("pre_rst_wdata", axi.wdata, 32'h5555_0004);
        mem_wen = 1'b0;
        rst     = 1'b0;
        #1;
        chk("mid_rst_awvalid", axi.awvalid, 1'b0);
        chk("mid_rst_wvalid", axi.wvalid, 1'b0);
        chk("mid_rst_bready", axi.bready, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_err", resp_err, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_xfer(32'h0000_6000, 32'h0000_6000, 32'h6666_0000, 2'b00, 0, 0, 0, 1, 11);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
